// File: rtl/axi4lite_master_if.sv
// Bundle of the command/response port and the five AXI4-Lite channels
// between axi4lite_master and its neighbours.
//   master modport : the axi4lite_master view. It takes CMD_* and RSP_READY in,
//                    drives RSP_* and TIMEOUT, and owns the master side of AW/W/B/AR/R.
//   slave modport  : the opposite view, used by whatever drives the command port
//                    and models the downstream slave.
interface axi4lite_master_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    // command / response port
    logic                  CMD_VALID;
    logic                  CMD_READY;
    logic                  CMD_WRITE;
    logic [ADDR_WIDTH-1:0] CMD_ADDR;
    logic [2:0]            CMD_PROT;
    logic [DATA_WIDTH-1:0] CMD_WDATA;
    logic [STRB_WIDTH-1:0] CMD_WSTRB;
    logic                  RSP_VALID;
    logic                  RSP_READY;
    logic                  RSP_WRITE;
    logic [DATA_WIDTH-1:0] RSP_RDATA;
    logic [1:0]            RSP_RESP;
    logic                  TIMEOUT;

    // AXI4-Lite channels
    logic                  AW_VALID;
    logic                  AW_READY;
    logic [ADDR_WIDTH-1:0] AW_ADDR;
    logic [2:0]            AW_PROT;
    logic                  W_VALID;
    logic                  W_READY;
    logic [DATA_WIDTH-1:0] W_DATA;
    logic [STRB_WIDTH-1:0] W_STRB;
    logic                  B_VALID;
    logic                  B_READY;
    logic [1:0]            B_RESP;
    logic                  AR_VALID;
    logic                  AR_READY;
    logic [ADDR_WIDTH-1:0] AR_ADDR;
    logic [2:0]            AR_PROT;
    logic                  R_VALID;
    logic                  R_READY;
    logic [DATA_WIDTH-1:0] R_DATA;
    logic [1:0]            R_RESP;

    modport master (
        input  CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_PROT, CMD_WDATA, CMD_WSTRB, RSP_READY,
        output CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP, TIMEOUT,
        output AW_VALID, AW_ADDR, AW_PROT, input AW_READY,
        output W_VALID, W_DATA, W_STRB, input W_READY,
        input  B_VALID, B_RESP, output B_READY,
        output AR_VALID, AR_ADDR, AR_PROT, input AR_READY,
        input  R_VALID, R_DATA, R_RESP, output R_READY
    );

    modport slave (
        output CMD_VALID, CMD_WRITE, CMD_ADDR, CMD_PROT, CMD_WDATA, CMD_WSTRB, RSP_READY,
        input  CMD_READY, RSP_VALID, RSP_WRITE, RSP_RDATA, RSP_RESP, TIMEOUT,
        input  AW_VALID, AW_ADDR, AW_PROT, output AW_READY,
        input  W_VALID, W_DATA, W_STRB, output W_READY,
        output B_VALID, B_RESP, input B_READY,
        input  AR_VALID, AR_ADDR, AR_PROT, output AR_READY,
        output R_VALID, R_DATA, R_RESP, input R_READY
    );
endinterface

// File: rtl/axi4lite_master.sv
// AXI4-Lite master. It accepts one read or write command at a time from a
// valid/ready command port and runs the AW/W/B or AR/R handshakes. It then
// presents the read data or write response on a valid/ready response port.
// A watchdog raises a sticky TIMEOUT flag when a transaction stalls too long.
// The flag does not abort the transaction.
// Ports:
//   A_CLK - clock, rising edge
//   A_RST - asynchronous active-high reset
//   bus   - axi4lite_master_if.master carrying:
//           CMD_* : command port
//           RSP_* : response port
//           TIMEOUT : sticky watchdog flag
//           AW/W/B/AR/R : AXI4-Lite channels
// DATA_WIDTH is expected to be 32 or 64.
// TIMEOUT_CYCLES = 0 disables the watchdog.
module axi4lite_master #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 256
) (
    input  logic               A_CLK,
    input  logic               A_RST,
    axi4lite_master_if.master  bus
);
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;
    localparam int unsigned CNT_W      = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);
    localparam bit WD_EN = (TIMEOUT_CYCLES != 0);

    typedef enum logic [2:0] {IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, RESP} state_t;

    state_t                state_q, state_d;
    logic                  cmd_ready_q, cmd_ready_d;
    logic                  aw_valid_q, aw_valid_d;
    logic                  w_valid_q, w_valid_d;
    logic                  ar_valid_q, ar_valid_d;
    logic                  b_ready_q, b_ready_d;
    logic                  r_ready_q, r_ready_d;
    logic                  rsp_valid_q, rsp_valid_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [2:0]            prot_q, prot_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [STRB_WIDTH-1:0] wstrb_q, wstrb_d;
    logic                  rsp_write_q, rsp_write_d;
    logic [DATA_WIDTH-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [1:0]            rsp_resp_q, rsp_resp_d;
    logic [CNT_W-1:0]      wd_cnt_q, wd_cnt_d;
    logic                  timeout_q, timeout_d;
    logic                  bus_phase;

    // State and all registered outputs
    always_ff @(posedge A_CLK or posedge A_RST) begin
        if (A_RST) begin
            state_q     <= IDLE;
            cmd_ready_q <= 1'b0;
            aw_valid_q  <= 1'b0;
            w_valid_q   <= 1'b0;
            ar_valid_q  <= 1'b0;
            b_ready_q   <= 1'b0;
            r_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b0;
            addr_q      <= '0;
            prot_q      <= '0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_resp_q  <= '0;
            wd_cnt_q    <= '0;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cmd_ready_q <= cmd_ready_d;
            aw_valid_q  <= aw_valid_d;
            w_valid_q   <= w_valid_d;
            ar_valid_q  <= ar_valid_d;
            b_ready_q   <= b_ready_d;
            r_ready_q   <= r_ready_d;
            rsp_valid_q <= rsp_valid_d;
            addr_q      <= addr_d;
            prot_q      <= prot_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_resp_q  <= rsp_resp_d;
            wd_cnt_q    <= wd_cnt_d;
            timeout_q   <= timeout_d;
        end
    end

    assign bus_phase = (state_q == WR_REQ) || (state_q == WR_RESP) ||
                       (state_q == RD_REQ) || (state_q == RD_DATA);

    // Next-state, channel sequencing and watchdog
    always_comb begin
        state_d     = state_q;
        cmd_ready_d = cmd_ready_q;
        aw_valid_d  = aw_valid_q;
        w_valid_d   = w_valid_q;
        ar_valid_d  = ar_valid_q;
        b_ready_d   = b_ready_q;
        r_ready_d   = r_ready_q;
        rsp_valid_d = rsp_valid_q;
        addr_d      = addr_q;
        prot_d      = prot_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_resp_d  = rsp_resp_q;
        wd_cnt_d    = wd_cnt_q;
        timeout_d   = timeout_q;

        case (state_q)
            IDLE: begin
                cmd_ready_d = 1'b1;
                if (bus.CMD_VALID && cmd_ready_q) begin
                    cmd_ready_d = 1'b0;
                    addr_d      = bus.CMD_ADDR;
                    prot_d      = bus.CMD_PROT;
                    wdata_d     = bus.CMD_WDATA;
                    wstrb_d     = bus.CMD_WSTRB;
                    timeout_d   = 1'b0;
                    if (bus.CMD_WRITE) begin
                        state_d    = WR_REQ;
                        aw_valid_d = 1'b1;
                        w_valid_d  = 1'b1;
                    end else begin
                        state_d    = RD_REQ;
                        ar_valid_d = 1'b1;
                    end
                end
            end
            WR_REQ: begin
                // AW and W retire independently; a stray READY after retirement is harmless
                aw_valid_d = aw_valid_q && !bus.AW_READY;
                w_valid_d  = w_valid_q && !bus.W_READY;
                if (!aw_valid_d && !w_valid_d) begin
                    state_d   = WR_RESP;
                    b_ready_d = 1'b1;
                end
            end
            WR_RESP: begin
                if (bus.B_VALID && b_ready_q) begin
                    b_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b1;
                    rsp_rdata_d = '0;
                    rsp_resp_d  = bus.B_RESP;
                    state_d     = RESP;
                end
            end
            RD_REQ: begin
                ar_valid_d = ar_valid_q && !bus.AR_READY;
                if (!ar_valid_d) begin
                    state_d   = RD_DATA;
                    r_ready_d = 1'b1;
                end
            end
            RD_DATA: begin
                if (bus.R_VALID && r_ready_q) begin
                    r_ready_d   = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = 1'b0;
                    rsp_rdata_d = bus.R_DATA;
                    rsp_resp_d  = bus.R_RESP;
                    state_d     = RESP;
                end
            end
            RESP: begin
                if (bus.RSP_READY) begin
                    rsp_valid_d = 1'b0;
                    cmd_ready_d = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Watchdog: counts bus-phase cycles, saturates at the limit, and clears on entering IDLE
        if (WD_EN && bus_phase && (wd_cnt_q != CNT_MAX)) begin
            wd_cnt_d = wd_cnt_q + CNT_W'(1);
        end
        if (state_d == IDLE) begin
            wd_cnt_d = '0;
        end
        if (WD_EN && bus_phase && (wd_cnt_d == CNT_MAX)) begin
            timeout_d = 1'b1;
        end
    end

    assign bus.CMD_READY = cmd_ready_q;
    assign bus.RSP_VALID = rsp_valid_q;
    assign bus.RSP_WRITE = rsp_write_q;
    assign bus.RSP_RDATA = rsp_rdata_q;
    assign bus.RSP_RESP  = rsp_resp_q;
    assign bus.TIMEOUT   = timeout_q;
    assign bus.AW_VALID  = aw_valid_q;
    assign bus.AW_ADDR   = addr_q;
    assign bus.AW_PROT   = prot_q;
    assign bus.W_VALID   = w_valid_q;
    assign bus.W_DATA    = wdata_q;
    assign bus.W_STRB    = wstrb_q;
    assign bus.B_READY   = b_ready_q;
    assign bus.AR_VALID  = ar_valid_q;
    assign bus.AR_ADDR   = addr_q;
    assign bus.AR_PROT   = prot_q;
    assign bus.R_READY   = r_ready_q;
endmodule
